ps2_scancode_decoder: RTL

Converts the raw PS/2 Set-2 byte stream from the keyboard receive path into one key event per keystroke. Prefixes (E0, F0, E1 pause sequence) are folded into flags, and live modifier/Caps-Lock state is tracked. Keyboard status bytes (ACK, BAT, errors) are reported as strobes rather than as key events. The block sits directly downstream of the PS/2 receive FIFO (device-clock side) and feeds the keyboard event queue or the interrupt logic.

---
 rtl/ps2_scancode_decoder.sv | 117 +++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: folds E0/F0/E1 prefixes into event flags,
// tracks modifier and Caps-Lock state, and reports status bytes as strobes.
module ps2_scancode_decoder #(
  parameter bit CAPS_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [10:0] m_data,
  output logic [3:0]  mods,
  output logic        ackStb,
  output logic        batStb,
  output logic        errStb
);

  typedef enum logic [2:0] {
    IDLE,
    PRE_E0,
    PRE_F0,
    PRE_E0F0,
    PAUSE
  } state_t;

  state_t     state;
  logic [2:0] pcnt;
  logic       lShift, rShift, lCtrl, rCtrl, lAlt, rAlt;
  logic       caps, capsHeld;
  logic       accept;
  logic       isExt, isBrk, isStatus;

  assign s_ready = ~m_valid;
  assign accept  = s_valid & ~m_valid;
  assign mods    = {caps, lAlt | rAlt, lCtrl | rCtrl, lShift | rShift};

  always_comb begin
    isExt    = (state == PRE_E0) || (state == PRE_E0F0);
    isBrk    = (state == PRE_F0) || (state == PRE_E0F0);
    isStatus = (s_data == 8'hFA) || (s_data == 8'hAA) || (s_data == 8'h00) ||
               (s_data == 8'hFC) || (s_data == 8'hFF);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      pcnt     <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      ackStb   <= 1'b0;
      batStb   <= 1'b0;
      errStb   <= 1'b0;
      lShift   <= 1'b0;
      rShift   <= 1'b0;
      lCtrl    <= 1'b0;
      rCtrl    <= 1'b0;
      lAlt     <= 1'b0;
      rAlt     <= 1'b0;
      capsHeld <= 1'b0;
      caps     <= CAPS_INIT;
    end else begin
      ackStb <= 1'b0;
      batStb <= 1'b0;
      errStb <= 1'b0;
      if (m_valid && m_ready)
        m_valid <= 1'b0;

      if (accept) begin
        if (state == PAUSE) begin
          if (pcnt == 3'd6) begin
            m_valid <= 1'b1;
            m_data  <= {3'b100, 8'hE1};
            pcnt    <= '0;
            state   <= IDLE;
          end else begin
            pcnt <= pcnt + 3'd1;
          end
        end else if (isStatus) begin
          ackStb <= (s_data == 8'hFA);
          batStb <= (s_data == 8'hAA);
          errStb <= (s_data != 8'hFA) && (s_data != 8'hAA);
          state  <= IDLE;
        end else if (s_data == 8'hE1) begin
          pcnt  <= '0;
          state <= PAUSE;
        end else if (s_data == 8'hF0) begin
          if (state == IDLE)
            state <= PRE_F0;
          else if (state == PRE_E0)
            state <= PRE_E0F0;
        end else if ((s_data == 8'hE0) && (state != PRE_F0)) begin
          if (state == IDLE)
            state <= PRE_E0;
        end else begin
          // Key event; an E0 after a lone F0 has no prefix meaning and lands here
          m_valid <= 1'b1;
          m_data  <= {1'b0, isBrk, isExt, s_data};
          state   <= IDLE;
          if (!isExt && (s_data == 8'h12)) lShift <= ~isBrk;
          if (!isExt && (s_data == 8'h59)) rShift <= ~isBrk;
          if (!isExt && (s_data == 8'h14)) lCtrl  <= ~isBrk;
          if ( isExt && (s_data == 8'h14)) rCtrl  <= ~isBrk;
          if (!isExt && (s_data == 8'h11)) lAlt   <= ~isBrk;
          if ( isExt && (s_data == 8'h11)) rAlt   <= ~isBrk;
          if (!isExt && (s_data == 8'h58)) begin
            capsHeld <= ~isBrk;
            if (!isBrk && !capsHeld)
              caps <= ~caps;
          end
        end
      end
    end
  end

endmodule
